// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
// Results are computed at issue, parked in pending registers, and committed when the busy window ends.
//   state    | meaning
//   IDLE     | no operation in flight; MTHI/MTLO and new starts accepted
//   MULT_RUN | multiply in flight, counting down MULT_CYCLES
//   DIV_RUN  | divide in flight, counting down DIV_CYCLES
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        hilo_sel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] md_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, MULT_RUN, DIV_RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

    logic [63:0] prod_s, prod_u;
    logic        signed_div, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};
    end

    // Signed divide done on magnitudes so INT_MIN / -1 wraps to INT_MIN instead of overflowing.
    always_comb begin
        signed_div = (md_op == OP_DIV);
        a_neg      = signed_div & A[31];
        b_neg      = signed_div & B[31];
        a_mag      = a_neg ? (~A + 32'd1) : A;
        b_mag      = b_neg ? (~B + 32'd1) : B;
        q_mag      = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
        r_mag      = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
        quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem        = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (md_op == OP_MULT || md_op == OP_MULTU) begin
                        {pend_hi_d, pend_lo_d} = (md_op == OP_MULT) ? prod_s : prod_u;
                        cnt_d   = MULT_LOAD;
                        state_d = MULT_RUN;
                    end else if (md_op == OP_DIV || md_op == OP_DIVU) begin
                        // Divide by zero still occupies the unit but commits the old HI/LO.
                        if (B == 32'd0) begin
                            pend_hi_d = hi_q;
                            pend_lo_d = lo_q;
                        end else begin
                            pend_hi_d = rem;
                            pend_lo_d = quot;
                        end
                        cnt_d   = DIV_LOAD;
                        state_d = DIV_RUN;
                    end
                end else if (md_op == OP_MTHI) begin
                    hi_d = A;
                end else if (md_op == OP_MTLO) begin
                    lo_d = A;
                end
            end
            MULT_RUN, DIV_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign HI     = hi_q;
    assign LO     = lo_q;
    assign md_out = hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic        hilo_sel;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO, md_out;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] hi_m, lo_m;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .hilo_sel(hilo_sel),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .md_out(md_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic, {HI,LO} result.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] res;
        res = {hi, lo};
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        case (op)
            3'd1: res = 64'(sa * sb);
            3'd2: res = {32'd0, a} * {32'd0, b};
            3'd3: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            3'd4: if (b != 0) res = {a % b, a / b};
            default: res = {hi, lo};
        endcase
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue op, optionally drive (inj_start, inj_op) during busy cycle inj_cyc+1, check length and result.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n, input int inj_cyc,
                         input logic inj_start, input logic [2:0] inj_op);
        logic [63:0] exp;
        int cnt;
        exp = model(op, a, b, hi_m, lo_m);
        start = 1'b1; md_op = op; A = a; B = b;
        tick();
        start = 1'b0; md_op = 3'd0;
        cnt = 0;
        while (busy && cnt < 100) begin
            if (cnt == 0) begin
                hilo_sel = 1'b1;
                #1;
                check({tag, "_mdout_busy"}, md_out, hi_m);
            end
            if (cnt == inj_cyc) begin
                start = inj_start; md_op = inj_op; A = $urandom; B = $urandom;
            end else begin
                start = 1'b0; md_op = 3'd0;
            end
            tick();
            cnt++;
        end
        start = 1'b0; md_op = 3'd0;
        check({tag, "_busy_len"}, 32'(cnt), 32'(n));
        hi_m = exp[63:32];
        lo_m = exp[31:0];
        check({tag, "_hi"}, HI, hi_m);
        check({tag, "_lo"}, LO, lo_m);
        hilo_sel = 1'b0;
        #1;
        check({tag, "_mdout_lo"}, md_out, lo_m);
    endtask

    task automatic move(input string tag, input logic [2:0] op, input logic [31:0] a);
        start = 1'b0; md_op = op; A = a;
        tick();
        md_op = 3'd0;
        if (op == 3'd5) hi_m = a;
        if (op == 3'd6) lo_m = a;
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_hi"}, HI, hi_m);
        check({tag, "_lo"}, LO, lo_m);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; md_op = 3'd0; hilo_sel = 1'b0; A = '0; B = '0;
        hi_m = '0; lo_m = '0;
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_mdout", md_out, 32'd0);
        reset = 1'b1;

        do_op("mult", 3'd1, 32'hFFFFFFFF, 32'd2, 5, -1, 1'b0, 3'd0);
        check("mult_hi_const", HI, 32'hFFFFFFFF);
        check("mult_lo_const", LO, 32'hFFFFFFFE);
        do_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 5, -1, 1'b0, 3'd0);
        check("multu_hi_const", HI, 32'h00000001);
        check("multu_lo_const", LO, 32'hFFFFFFFE);
        do_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, 10, -1, 1'b0, 3'd0);
        check("div_lo_const", LO, 32'hFFFFFFFD);
        check("div_hi_const", HI, 32'hFFFFFFFF);
        do_op("divu", 3'd4, 32'd7, 32'd2, 10, -1, 1'b0, 3'd0);
        check("divu_lo_const", LO, 32'd3);
        check("divu_hi_const", HI, 32'd1);

        move("mthi11", 3'd5, 32'h11);
        move("mtlo22", 3'd6, 32'h22);
        do_op("divu_by0", 3'd4, 32'd5, 32'd0, 10, -1, 1'b0, 3'd0);
        check("div0_hi_const", HI, 32'h11);
        check("div0_lo_const", LO, 32'h22);

        do_op("mult_restart", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5, 1, 1'b1, 3'd3);
        move("mtlo_abcd", 3'd6, 32'hABCD);
        do_op("div_mthi", 3'd3, 32'd100, 32'hFFFF_FFFD, 10, 3, 1'b0, 3'd5);
        do_op("div_min", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, -1, 1'b0, 3'd0);
        check("div_min_lo_const", LO, 32'h8000_0000);
        check("div_min_hi_const", HI, 32'd0);

        for (int k = 0; k < 8; k++) begin
            start = 1'b1; md_op = (k[0]) ? 3'd7 : 3'd0; A = $urandom; B = $urandom;
            tick();
            start = 1'b0; md_op = 3'd0;
            check("ignored_busy", 32'(busy), 32'd0);
            check("ignored_hi", HI, hi_m);
            check("ignored_lo", LO, lo_m);
        end

        for (int k = 0; k < 24; k++) begin
            logic [2:0] op;
            logic [31:0] ra, rb;
            op = 3'($urandom_range(1, 4));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (k % 3 == 0) rb = 32'($urandom_range(1, 9));
            do_op("rand", op, ra, rb, (op <= 3'd2) ? 5 : 10, -1, 1'b0, 3'd0);
        end

        start = 1'b1; md_op = 3'd3; A = 32'd1000; B = 32'd7;
        tick();
        start = 1'b0; md_op = 3'd0;
        tick(); tick(); tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        hi_m = '0; lo_m = '0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hi", HI, 32'd0);
        check("midrst_lo", LO, 32'd0);
        tick(); tick();
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("postrst_busy", 32'(busy), 32'd0);
            check("postrst_hi", HI, 32'd0);
            check("postrst_lo", LO, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration in cycles of a multiply.
REQ-002 Parameter DIV_CYCLES, default 10, busy duration in cycles of a divide.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; E stage issues MULT/MULTU/DIV/DIVU this cycle.
REQ-006 md_op  input  3  operation: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 reserved.
REQ-007 hilo_sel  input  1  read select for MFHI/MFLO: 1 HI, 0 LO.
REQ-008 A  input  32  rs operand, forwarded value from E stage.
REQ-009 B  input  32  rt operand, forwarded value from E stage.
REQ-010 busy  output  1  operation in flight; feeds the stall unit's Busy input.
REQ-011 HI  output  32  architectural HI register.
REQ-012 LO  output  32  architectural LO register.
REQ-013 md_out  output  32  hilo_sel ? HI : LO, combinational, for MFHI/MFLO writeback.

Function
REQ-014 States IDLE, MULT_RUN, DIV_RUN; busy = (state != IDLE).
REQ-015 Registered cycle counter, width ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)).
REQ-016 IDLE + start + md_op in {1,2}: latch product into pending_hi/pending_lo, counter <= MULT_CYCLES, go MULT_RUN.
REQ-017 IDLE + start + md_op in {3,4}: latch quotient into pending_lo and remainder into pending_hi, counter <= DIV_CYCLES, go DIV_RUN.
REQ-018 MULT: {HI,LO} = 64-bit product; signed when md_op=1, unsigned when md_op=2.
REQ-019 DIV signed (md_op=3): quotient truncated toward zero, remainder takes sign of dividend; DIVU: both unsigned.
REQ-020 In MULT_RUN/DIV_RUN: counter decrements each cycle; on the edge where counter is 1, HI <= pending_hi, LO <= pending_lo, counter <= 0, state <= IDLE.
REQ-021 busy high for exactly N cycles, N = MULT_CYCLES or DIV_CYCLES, starting the cycle after the start edge; new HI/LO visible the first cycle busy is low.
REQ-022 start high while busy: ignored, no state change, in-flight op unaffected; the stall unit prevents this, the block still tolerates it.
REQ-023 start with md_op in {0,5,6,7}: ignored.
REQ-024 md_op=5 (MTHI) while IDLE and start low: HI <= A at next edge, single cycle, busy stays low; md_op=6 (MTLO): LO <= A likewise.
REQ-025 MTHI/MTLO while busy: ignored.
REQ-026 Divide with B == 0: operation proceeds through DIV_RUN for full DIV_CYCLES; HI and LO keep their pre-operation values at completion.
REQ-027 Signed DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wrap, no trap).
REQ-028 md_op = 7: no effect on any state.
REQ-029 md_out reflects the current HI/LO register contents, never pending values, including during busy.

Reset
REQ-030 reset low asynchronously: state <= IDLE, counter <= 0, HI <= 0, LO <= 0, pending regs <= 0; busy low within the same cycle.
REQ-031 reset asserted mid-operation: operation abandoned, HI/LO = 0, no late write after reset deasserts.
REQ-032 First start accepted on the first rising edge after reset deasserts.

Verification
REQ-033 MULT A=0xFFFFFFFF B=2 -> busy high 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE; MULTU same operands -> HI=0x00000001 LO=0xFFFFFFFE.
REQ-034 DIV A=-7 (0xFFFFFFF9) B=2 -> busy high 10 cycles, then LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU A=7 B=2 -> LO=3 HI=1.
REQ-035 HI=0x11, LO=0x22; DIVU A=5 B=0 -> busy 10 cycles, then HI=0x11 LO=0x22 unchanged.
REQ-036 MULT start, second start (DIV) pulsed in busy cycle 2 -> busy drops after exactly 5 cycles, HI/LO = MULT result only.
REQ-037 MTLO A=0xABCD while idle -> LO=0xABCD next cycle, busy never high; MTHI A=1 during DIV busy -> HI unchanged by the MTHI.
REQ-038 DIV start, reset low in busy cycle 4, released 2 cycles later -> busy low immediately, HI=LO=0, both stay 0 for 12 further cycles.
